// File: rtl/dpu_seq.sv
// Clocked DPU: registered ALU behind a valid/ready handshake, shift-add multiplier,
// output select and a multiplexed seven-segment scanner. Optional feature macro: DPU_ACC_EN.
module dpu_seq #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
`ifdef DPU_ACC_EN
  input  logic                 acc_sel,
`endif
  output logic                 in_ready,
  input  logic [1:0]           dsel,
  output logic                 out_valid,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   dout,
  output logic [6:0]           seg,
  output logic [DIGITS-1:0]    an
);

  localparam int unsigned RW      = 2 * WIDTH;
  localparam int unsigned CntW    = $clog2(SCAN_DIV);
  localparam int unsigned IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned MulCntW = $clog2(WIDTH);
  localparam int unsigned ExtW    = 4 * DIGITS + RW;

  localparam logic [MulCntW-1:0] MulLast  = MulCntW'(WIDTH - 1);
  localparam logic [CntW-1:0]    ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]    IdxLast  = IdxW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     rega_q, rega_d, regb_q, regb_d;
  logic [RW-1:0]        result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic [RW-1:0]        prod_q, prod_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [MulCntW-1:0]   mcnt_q, mcnt_d;
  logic [CntW-1:0]      scan_cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [6:0]           seg_q;
  logic [DIGITS-1:0]    an_q;

  logic                 accept;
  logic [WIDTH-1:0]     a_src;
  logic [WIDTH:0]       sum, diff;
  logic [RW-1:0]        alu_res, prod_step;
  logic                 alu_c, alu_v;
  logic [ExtW-1:0]      ext;
  logic [3:0]           nibble;
  logic                 scan_wrap;

  assign accept = in_valid && (state_q == StIdle);

`ifdef DPU_ACC_EN
  // Chained operation: A comes from the low half of the previous result.
  assign a_src = acc_sel ? result_q[WIDTH-1:0] : a;
`else
  assign a_src = a;
`endif

  // ALU on the latched operands; carry/borrow lands in bit WIDTH of sum/diff.
  always_comb begin
    sum     = {1'b0, rega_q} + {1'b0, regb_q};
    diff    = {1'b0, rega_q} - {1'b0, regb_q};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      3'd0: begin
        alu_res[WIDTH:0] = sum;
        alu_c            = sum[WIDTH];
        alu_v            = (rega_q[WIDTH-1] == regb_q[WIDTH-1]) &&
                           (sum[WIDTH-1] != rega_q[WIDTH-1]);
      end
      3'd1: begin
        alu_res[WIDTH-1:0] = diff[WIDTH-1:0];
        alu_c              = diff[WIDTH];
        alu_v              = (rega_q[WIDTH-1] != regb_q[WIDTH-1]) &&
                             (diff[WIDTH-1] != rega_q[WIDTH-1]);
      end
      3'd2:    alu_res[WIDTH-1:0] = rega_q & regb_q;
      3'd3:    alu_res[WIDTH-1:0] = rega_q | regb_q;
      3'd4:    alu_res[WIDTH-1:0] = rega_q ^ regb_q;
      3'd5:    alu_res[WIDTH-1:0] = ~rega_q;
      3'd6:    alu_res[WIDTH:0]   = {rega_q, 1'b0};
      default: alu_res = '0;
    endcase
  end

  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rega_d   = rega_q;
    regb_d   = regb_q;
    result_d = result_q;
    flags_d  = flags_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mcnt_d   = mcnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d     = op;
          rega_d   = a_src;
          regb_d   = b;
          prod_d   = '0;
          mcand_d  = {{(RW-WIDTH){1'b0}}, a_src};
          mplier_d = b;
          mcnt_d   = '0;
          state_d  = (op == 3'd7) ? StMul : StExec;
        end
      end
      StExec: begin
        result_d = alu_res;
        flags_d  = {alu_res == '0, alu_c, alu_res[WIDTH-1], alu_v};
        state_d  = StDone;
      end
      StMul: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        mcnt_d   = mcnt_q + 1'b1;
        if (mcnt_q == MulLast) begin
          result_d = prod_step;
          flags_d  = {prod_step == '0, 1'b0, prod_step[WIDTH-1], 1'b0};
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StExec) || (state_q == StMul);

  always_comb begin
    dout = '0;
    case (dsel)
      2'd0:    dout = result_q;
      2'd1:    dout[WIDTH-1:0] = rega_q;
      2'd2:    dout[WIDTH-1:0] = regb_q;
      default: dout[4:0] = {busy, flags_q};
    endcase
  end

  // Zero padding above dout makes digits beyond the result width show 0.
  assign ext       = {{(4*DIGITS){1'b0}}, dout};
  assign nibble    = 4'(ext >> (4 * idx_q));
  assign scan_wrap = (scan_cnt_q == ScanLast);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      rega_q     <= '0;
      regb_q     <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      mcnt_q     <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= 7'b1111111;
      an_q       <= '1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rega_q     <= rega_d;
      regb_q     <= regb_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      mcnt_q     <= mcnt_d;
      scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + 1'b1;
      // Each wrap latches the current digit, then moves on to the next one.
      if (scan_wrap) begin
        seg_q <= hex7(nibble);
        an_q  <= ~(DIGITS'(1) << idx_q);
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_dpu_seq.sv
// Self-checking bench for dpu_seq: directed cases plus random ops against an
// arithmetic reference model, reset abort during MUL and seven-seg scanning.
module tb_dpu_seq;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int SD = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          in_valid, acc_sel;
  logic          in_ready, out_valid, busy;
  logic [1:0]    dsel;
  logic [RW-1:0] dout;
  logic [6:0]    seg;
  logic [D-1:0]  an;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] prev_res;

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  dpu_seq #(.WIDTH(W), .DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
`ifdef DPU_ACC_EN
    .acc_sel  (acc_sel),
`endif
    .in_ready (in_ready),
    .dsel     (dsel),
    .out_valid(out_valid),
    .busy     (busy),
    .dout     (dout),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input int o, input int x, input int y,
                                output logic [RW-1:0] r, output logic [3:0] f);
    int full, half, sx, sy, s, res;
    logic c, v;
    full = 1 << W;
    half = 1 << (W - 1);
    sx = (x >= half) ? x - full : x;
    sy = (y >= half) ? y - full : y;
    c = 1'b0;
    v = 1'b0;
    case (o)
      0: begin res = x + y; c = (res >= full); s = sx + sy; v = (s < -half) || (s >= half); end
      1: begin res = (x - y + full) % full; c = (x < y); s = sx - sy;
               v = (s < -half) || (s >= half); end
      2: res = x & y;
      3: res = x | y;
      4: res = x ^ y;
      5: res = full - 1 - x;
      6: res = x * 2;
      default: res = x * y;
    endcase
    r = RW'(res);
    f = {res == 0, c, ((res >> (W - 1)) & 1) == 1, v};
  endfunction

  task automatic do_op(input int o, input int x, input int y, input bit acc, input bit hold);
    int ea, n, lat;
    logic [RW-1:0] er;
    logic [3:0] ef;
    ea = acc ? int'(prev_res[W-1:0]) : x;
    model(o, ea, y, er, ef);
    @(negedge clk);
    check("ready_idle", in_ready, 1);
    op = 3'(o); a = W'(x); b = W'(y); acc_sel = acc; in_valid = 1'b1; dsel = 2'd0;
    @(negedge clk);
    if (hold) begin
      op = 3'(o ^ 1); a = W'(x + 3); b = W'(y + 5);
    end else begin
      in_valid = 1'b0;
    end
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      check("busy_inflight", busy, 1);
      check("ready_inflight", in_ready, 0);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    lat = (o == 7) ? W + 1 : 2;
    check("latency", n, lat);
    dsel = 2'd0; #1 check("result", dout, er);
    dsel = 2'd1; #1 check("rega", dout, ea);
    dsel = 2'd2; #1 check("regb", dout, y);
    dsel = 2'd3; #1 check("flags", dout, {4'b0, ef});
    dsel = 2'd0;
    @(negedge clk);
    check("valid_pulse", out_valid, 0);
    check("ready_after", in_ready, 1);
    prev_res = er;
  endtask

  initial begin
    int k, nib;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; acc_sel = 1'b0; dsel = 2'd0;
    prev_res = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_seg", seg, 7'b1111111);
    check("rst_an", an, 4'b1111);
    check("rst_result", dout, 0);
    dsel = 2'd3; #1 check("rst_flags", dout, 0);
    dsel = 2'd0;
    rst = 1'b0;
    repeat (SD - 1) begin
      @(negedge clk);
      check("an_before_wrap", an, 4'b1111);
    end
    @(negedge clk);
    check("an_first_wrap", an, 4'b1110);
    check("seg_first_wrap", seg, 7'b0000001);

    do_op(0, 9, 8, 0, 0);
    do_op(1, 3, 5, 0, 0);
    do_op(1, 5, 5, 0, 0);
    do_op(7, 15, 15, 0, 1);
    do_op(6, 12, 0, 0, 0);
    do_op(7, 0, 0, 0, 0);

    // Scanner on result 0x5A
    do_op(7, 15, 6, 0, 0);
    k = 0;
    while (an === 4'b1110 && k < 40) begin @(negedge clk); k++; end
    while (an !== 4'b1110 && k < 40) begin @(negedge clk); k++; end
    for (int d = 0; d < D; d++) begin
      nib = (int'(prev_res) >> (4 * d)) & 15;
      check("scan_an", an, ~(4'b0001 << d) & 4'hf);
      check("scan_seg", seg, seg_tab[nib]);
      repeat (SD) @(negedge clk);
    end
    check("scan_an_wrap", an, 4'b1110);

`ifdef DPU_ACC_EN
    do_op(0, 3, 4, 0, 0);
    do_op(0, 0, 2, 1, 0);
`endif

    repeat (40) begin
`ifdef DPU_ACC_EN
      acc = 1'($urandom_range(0, 1));
`else
      acc = 1'b0;
`endif
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), acc, 0);
    end

    // Reset during MUL cycle 2 aborts the operation.
    @(negedge clk);
    op = 3'd7; a = 4'd15; b = 4'd15; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mul_busy_pre_rst", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    check("abort_result", dout, 0);
    check("abort_seg", seg, 7'b1111111);
    check("abort_an", an, 4'b1111);
    @(negedge clk);
    rst = 1'b0;
    prev_res = '0;
    repeat (W + 3) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
    end
    do_op(2, 12, 10, 0, 0);
    do_op(4, 12, 10, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
